// File: rtl/tl_param_queue_if.sv
// Enqueue/dequeue handshake bundle for tl_param_queue.
// io_high_water is present only when TL_QUEUE_HIGH_WATER_EN is defined.
interface tl_param_queue_if #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             io_enq_ready;
    logic             io_enq_valid;
    logic [WIDTH-1:0] io_enq_bits;
    logic             io_deq_ready;
    logic             io_deq_valid;
    logic [WIDTH-1:0] io_deq_bits;
    logic [CW-1:0]    io_count;
`ifdef TL_QUEUE_HIGH_WATER_EN
    logic [CW-1:0]    io_high_water;

    modport master (
        output io_enq_valid, io_enq_bits, io_deq_ready,
        input  io_enq_ready, io_deq_valid, io_deq_bits, io_count, io_high_water
    );
    modport slave (
        input  io_enq_valid, io_enq_bits, io_deq_ready,
        output io_enq_ready, io_deq_valid, io_deq_bits, io_count, io_high_water
    );
`else
    modport master (
        output io_enq_valid, io_enq_bits, io_deq_ready,
        input  io_enq_ready, io_deq_valid, io_deq_bits, io_count
    );
    modport slave (
        input  io_enq_valid, io_enq_bits, io_deq_ready,
        output io_enq_ready, io_deq_valid, io_deq_bits, io_count
    );
`endif
endinterface

// File: rtl/tl_param_queue.sv
// Parametrised TileLink side-channel FIFO with optional pipe/flow bypass.
// Optional max-occupancy tracker enabled by TL_QUEUE_HIGH_WATER_EN.
module tl_param_queue #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2,
    parameter int PIPE  = 0,
    parameter int FLOW  = 0
) (
    input  logic           clock,
    input  logic           reset,
    tl_param_queue_if.slave q
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_enq_ptr;
    logic [PW-1:0]    r_deq_ptr;
    logic             r_maybe_full;

    logic             w_ptr_match;
    logic             w_empty;
    logic             w_full;
    logic             w_bypass;
    logic             w_do_enq;
    logic             w_do_deq;
    logic [PW-1:0]    w_enq_ptr_nxt;
    logic [PW-1:0]    w_deq_ptr_nxt;
    logic [CW-1:0]    w_count;

    assign w_ptr_match = (r_enq_ptr == r_deq_ptr);
    assign w_empty     = w_ptr_match & ~r_maybe_full;
    assign w_full      = w_ptr_match & r_maybe_full;

    // A beat transfers on each side at a rising edge where valid and ready are both high.
    // PIPE lets enq_ready follow deq_ready when full; FLOW lets deq_valid follow enq_valid when empty.
    assign q.io_enq_ready = ~w_full | ((PIPE != 0) & q.io_deq_ready);
    assign q.io_deq_valid = ~w_empty | ((FLOW != 0) & q.io_enq_valid);
    assign q.io_deq_bits  = ((FLOW != 0) && w_empty) ? q.io_enq_bits : r_mem[r_deq_ptr];

    // Flow-through beat: both sides fire but nothing touches the storage.
    assign w_bypass = (FLOW != 0) & w_empty & q.io_enq_valid & q.io_deq_ready;
    assign w_do_enq = q.io_enq_valid & q.io_enq_ready & ~w_bypass;
    assign w_do_deq = q.io_deq_ready & q.io_deq_valid & ~w_bypass;

    assign w_enq_ptr_nxt = (r_enq_ptr == LAST) ? '0 : r_enq_ptr + 1'b1;
    assign w_deq_ptr_nxt = (r_deq_ptr == LAST) ? '0 : r_deq_ptr + 1'b1;

    always_comb begin
        w_count = '0;
        if (w_full) begin
            w_count = CW'(DEPTH);
        end else if (r_enq_ptr >= r_deq_ptr) begin
            w_count = CW'(r_enq_ptr - r_deq_ptr);
        end else begin
            w_count = CW'(DEPTH) - CW'(r_deq_ptr) + CW'(r_enq_ptr);
        end
    end

    assign q.io_count = w_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_enq_ptr    <= '0;
            r_deq_ptr    <= '0;
            r_maybe_full <= 1'b0;
        end else begin
            if (w_do_enq) begin
                r_enq_ptr <= w_enq_ptr_nxt;
            end
            if (w_do_deq) begin
                r_deq_ptr <= w_deq_ptr_nxt;
            end
            if (w_do_enq != w_do_deq) begin
                r_maybe_full <= w_do_enq;
            end
        end
    end

    // Storage is never reset; an empty queue never exposes it.
    always_ff @(posedge clock) begin
        if (w_do_enq) begin
            r_mem[r_enq_ptr] <= q.io_enq_bits;
        end
    end

`ifdef TL_QUEUE_HIGH_WATER_EN
    logic [CW-1:0] r_high_water;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_high_water <= '0;
        end else if (w_count > r_high_water) begin
            r_high_water <= w_count;
        end
    end

    assign q.io_high_water = r_high_water;
`endif
endmodule

// File: tb/tb_tl_param_queue.sv
// Bench for tl_param_queue: five configurations driven by directed vectors,
// checked every cycle against a list-based occupancy model plus literal expectations.
module tb_tl_param_queue;
    localparam int N = 5;
    localparam int DEP [N] = '{2, 3, 2, 2, 4};
    localparam bit PIP [N] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam bit FLO [N] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam int WID [N] = '{2, 4, 2, 2, 4};

    logic clock;
    logic reset;
    logic chk_en;
    int   checks;
    int   errors;

    logic       d_ev [N];
    logic [3:0] d_eb [N];
    logic       d_dr [N];

    logic [N-1:0]      a_er;
    logic [N-1:0]      a_dv;
    logic [N-1:0][3:0] a_db;
    logic [N-1:0][2:0] a_cnt;
    logic [N-1:0][2:0] a_hw;

    logic [3:0] mbuf  [N][8];
    int         msize [N];
    int         mhw   [N];

    tl_param_queue_if #(.WIDTH(2), .DEPTH(2)) if0 ();
    tl_param_queue_if #(.WIDTH(4), .DEPTH(3)) if1 ();
    tl_param_queue_if #(.WIDTH(2), .DEPTH(2)) if2 ();
    tl_param_queue_if #(.WIDTH(2), .DEPTH(2)) if3 ();
    tl_param_queue_if #(.WIDTH(4), .DEPTH(4)) if4 ();

    tl_param_queue #(.WIDTH(2), .DEPTH(2), .PIPE(0), .FLOW(0)) u0 (.clock(clock), .reset(reset), .q(if0));
    tl_param_queue #(.WIDTH(4), .DEPTH(3), .PIPE(0), .FLOW(0)) u1 (.clock(clock), .reset(reset), .q(if1));
    tl_param_queue #(.WIDTH(2), .DEPTH(2), .PIPE(1), .FLOW(0)) u2 (.clock(clock), .reset(reset), .q(if2));
    tl_param_queue #(.WIDTH(2), .DEPTH(2), .PIPE(0), .FLOW(1)) u3 (.clock(clock), .reset(reset), .q(if3));
    tl_param_queue #(.WIDTH(4), .DEPTH(4), .PIPE(1), .FLOW(1)) u4 (.clock(clock), .reset(reset), .q(if4));

`define TB_HOOK(IDX, IFN, W) \
    assign IFN.io_enq_valid = d_ev[IDX]; \
    assign IFN.io_enq_bits  = d_eb[IDX][W-1:0]; \
    assign IFN.io_deq_ready = d_dr[IDX]; \
    assign a_er[IDX]  = IFN.io_enq_ready; \
    assign a_dv[IDX]  = IFN.io_deq_valid; \
    assign a_db[IDX]  = 4'(IFN.io_deq_bits); \
    assign a_cnt[IDX] = 3'(IFN.io_count);

    `TB_HOOK(0, if0, 2)
    `TB_HOOK(1, if1, 4)
    `TB_HOOK(2, if2, 2)
    `TB_HOOK(3, if3, 2)
    `TB_HOOK(4, if4, 4)

`ifdef TL_QUEUE_HIGH_WATER_EN
    assign a_hw[0] = 3'(if0.io_high_water);
    assign a_hw[1] = 3'(if1.io_high_water);
    assign a_hw[2] = 3'(if2.io_high_water);
    assign a_hw[3] = 3'(if3.io_high_water);
    assign a_hw[4] = 3'(if4.io_high_water);
`else
    assign a_hw = '0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic drv(input int i, input bit ev, input logic [3:0] eb, input bit dr);
        d_ev[i] = ev;
        d_eb[i] = eb & 4'((1 << WID[i]) - 1);
        d_dr[i] = dr;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) drv(i, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic next_cyc();
        @(posedge clock);
        #1;
    endtask

    // Model: each queue is an ordered list; outputs follow from its length and the inputs.
    always @(negedge clock) begin
        int         cnt;
        bit         exp_er;
        bit         exp_dv;
        bit         byp;
        bit         den;
        bit         ddq;
        logic [3:0] exp_db;
        for (int i = 0; i < N; i++) begin
            cnt    = msize[i];
            exp_er = (cnt < DEP[i]) || (PIP[i] && d_dr[i]);
            exp_dv = (cnt > 0) || (FLO[i] && d_ev[i]);
            exp_db = (cnt > 0) ? mbuf[i][0] : d_eb[i];
            if (chk_en) begin
                chk($sformatf("m%0d.enq_ready", i), 32'(a_er[i]), 32'(exp_er));
                chk($sformatf("m%0d.deq_valid", i), 32'(a_dv[i]), 32'(exp_dv));
                chk($sformatf("m%0d.count", i), 32'(a_cnt[i]), 32'(cnt));
                if (exp_dv) chk($sformatf("m%0d.deq_bits", i), 32'(a_db[i]), 32'(exp_db));
`ifdef TL_QUEUE_HIGH_WATER_EN
                chk($sformatf("m%0d.high_water", i), 32'(a_hw[i]), 32'(mhw[i]));
`endif
            end
            if (reset) begin
                msize[i] = 0;
                mhw[i]   = 0;
            end else begin
                if (cnt > mhw[i]) mhw[i] = cnt;
                byp = FLO[i] && (cnt == 0) && d_ev[i] && d_dr[i];
                ddq = !byp && d_dr[i] && (cnt > 0);
                den = !byp && d_ev[i] && exp_er;
                if (ddq) begin
                    for (int j = 0; j < 7; j++) mbuf[i][j] = mbuf[i][j+1];
                    msize[i] = msize[i] - 1;
                end
                if (den) begin
                    mbuf[i][msize[i]] = d_eb[i];
                    msize[i] = msize[i] + 1;
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        for (int i = 0; i < N; i++) begin
            msize[i] = 0;
            mhw[i]   = 0;
        end
        idle_all();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst%0d.count", i), 32'(a_cnt[i]), 32'd0);
            chk($sformatf("rst%0d.enq_ready", i), 32'(a_er[i]), 32'd1);
            chk($sformatf("rst%0d.deq_valid", i), 32'(a_dv[i]), 32'd0);
        end
        next_cyc();

        // Fill a 2-deep queue, drop a third beat, then drain.
        drv(0, 1'b1, 4'd1, 1'b0);
        @(negedge clock); chk("t1.count0", 32'(a_cnt[0]), 32'd0);
        next_cyc();
        drv(0, 1'b1, 4'd2, 1'b0);
        @(negedge clock); chk("t1.count1", 32'(a_cnt[0]), 32'd1);
        chk("t1.head1", 32'(a_db[0]), 32'd1);
        next_cyc();
        drv(0, 1'b1, 4'd3, 1'b0);
        @(negedge clock); chk("t1.count2", 32'(a_cnt[0]), 32'd2);
        chk("t1.full_ready", 32'(a_er[0]), 32'd0);
        next_cyc();
        drv(0, 1'b0, 4'd0, 1'b1);
        @(negedge clock); chk("t1.deq_a", 32'(a_db[0]), 32'd1);
        chk("t1.count_keep", 32'(a_cnt[0]), 32'd2);
        next_cyc();
        @(negedge clock); chk("t1.deq_b", 32'(a_db[0]), 32'd2);
        next_cyc();
        @(negedge clock); chk("t1.empty_valid", 32'(a_dv[0]), 32'd0);
        next_cyc();
        @(negedge clock); chk("t1.empty_count", 32'(a_cnt[0]), 32'd0);
        drv(0, 1'b0, 4'd0, 1'b0);
        next_cyc();

        // Stream 0..9 through a 3-deep queue across pointer wrap.
        for (int k = 0; k < 10; k++) begin
            drv(1, 1'b1, 4'(k), 1'b1);
            @(negedge clock);
            if (k == 0) begin
                chk("t2.count_first", 32'(a_cnt[1]), 32'd0);
            end else begin
                chk($sformatf("t2.count%0d", k), 32'(a_cnt[1]), 32'd1);
                chk($sformatf("t2.data%0d", k), 32'(a_db[1]), 32'(k - 1));
            end
            next_cyc();
        end
        drv(1, 1'b0, 4'd0, 1'b1);
        @(negedge clock); chk("t2.data9", 32'(a_db[1]), 32'd9);
        next_cyc();
        @(negedge clock); chk("t2.drained", 32'(a_cnt[1]), 32'd0);
        drv(1, 1'b0, 4'd0, 1'b0);
        next_cyc();

        // Pipe: enqueue into a full queue while the head leaves.
        drv(2, 1'b1, 4'd1, 1'b0); next_cyc();
        drv(2, 1'b1, 4'd2, 1'b0); next_cyc();
        drv(2, 1'b1, 4'd3, 1'b1);
        @(negedge clock); chk("t3.pipe_ready", 32'(a_er[2]), 32'd1);
        chk("t3.count_full", 32'(a_cnt[2]), 32'd2);
        chk("t3.head1", 32'(a_db[2]), 32'd1);
        next_cyc();
        drv(2, 1'b0, 4'd0, 1'b1);
        @(negedge clock); chk("t3.count_stay", 32'(a_cnt[2]), 32'd2);
        chk("t3.head2", 32'(a_db[2]), 32'd2);
        next_cyc();
        @(negedge clock); chk("t3.head3", 32'(a_db[2]), 32'd3);
        next_cyc();
        @(negedge clock); chk("t3.empty", 32'(a_dv[2]), 32'd0);
        drv(2, 1'b0, 4'd0, 1'b0);
        next_cyc();

        // Flow: same-cycle pass-through on an empty queue.
        drv(3, 1'b1, 4'd3, 1'b1);
        @(negedge clock); chk("t4.flow_valid", 32'(a_dv[3]), 32'd1);
        chk("t4.flow_bits", 32'(a_db[3]), 32'd3);
        chk("t4.flow_count", 32'(a_cnt[3]), 32'd0);
        next_cyc();
        drv(3, 1'b0, 4'd0, 1'b0);
        @(negedge clock); chk("t4.after_count", 32'(a_cnt[3]), 32'd0);
        next_cyc();
        drv(3, 1'b1, 4'd2, 1'b0);
        @(negedge clock); chk("t4.peek_bits", 32'(a_db[3]), 32'd2);
        next_cyc();
        drv(3, 1'b0, 4'd0, 1'b1);
        @(negedge clock); chk("t4.stored_count", 32'(a_cnt[3]), 32'd1);
        next_cyc();
        drv(3, 1'b0, 4'd0, 1'b0);
        next_cyc();

        // Fill a 4-deep queue to 3 and drain; occupancy peak is remembered.
        for (int k = 0; k < 3; k++) begin
            drv(4, 1'b1, 4'(k + 5), 1'b0);
            @(negedge clock); chk($sformatf("t6.fill%0d", k), 32'(a_cnt[4]), 32'(k));
            next_cyc();
        end
        drv(4, 1'b0, 4'd0, 1'b0);
        @(negedge clock); chk("t6.count3", 32'(a_cnt[4]), 32'd3);
`ifdef TL_QUEUE_HIGH_WATER_EN
        chk("t6.hw_lag", 32'(a_hw[4]), 32'd2);
`endif
        next_cyc();
        drv(4, 1'b0, 4'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock); chk($sformatf("t6.drain%0d", k), 32'(a_db[4]), 32'(k + 5));
            next_cyc();
        end
        drv(4, 1'b0, 4'd0, 1'b0);
        @(negedge clock); chk("t6.empty", 32'(a_cnt[4]), 32'd0);
`ifdef TL_QUEUE_HIGH_WATER_EN
        chk("t6.hw_hold", 32'(a_hw[4]), 32'd3);
`endif
        next_cyc();

        // Mixed traffic on every configuration, checked by the model.
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < N; i++) drv(i, (k % 3) != 2, 4'(k * 7 + i), (k % 4) < 2);
            next_cyc();
        end
        for (int i = 0; i < N; i++) drv(i, 1'b0, 4'd0, 1'b1);
        repeat (6) next_cyc();
        idle_all();

        // Reset while holding two entries.
        drv(0, 1'b1, 4'd1, 1'b0); next_cyc();
        drv(0, 1'b1, 4'd2, 1'b0); next_cyc();
        drv(0, 1'b0, 4'd0, 1'b0);
        @(negedge clock); chk("t5.pre_count", 32'(a_cnt[0]), 32'd2);
        next_cyc();
        reset = 1'b1;
        next_cyc();
        reset = 1'b0;
        @(negedge clock);
        chk("t5.count", 32'(a_cnt[0]), 32'd0);
        chk("t5.deq_valid", 32'(a_dv[0]), 32'd0);
        chk("t5.enq_ready", 32'(a_er[0]), 32'd1);
`ifdef TL_QUEUE_HIGH_WATER_EN
        chk("t5.hw", 32'(a_hw[4]), 32'd0);
`endif
        next_cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tl_param_queue.md
Name: tl_param_queue

Overview:
- Parametrised synchronous FIFO for TileLink-side channel buffering, e.g. E-channel sink IDs and small D/A-channel side fields.
- Successor to the fixed 2-entry sink queue:
  - generalised data width and depth;
  - adds a consumer-side ready;
  - adds optional pipe (full-bypass enqueue) and flow (empty-bypass dequeue) modes;
  - adds an occupancy count output.
- Sits between a channel producer and consumer inside the L1/L2 TileLink adapters.

Parameters:
- WIDTH, 2, payload width in bits (>=1).
- DEPTH, 2, number of entries (>=1, need not be a power of two).
- PIPE, 0, 1 = enq_ready also asserted when full and deq fires the same cycle.
- FLOW, 0, 1 = when empty, enq data passes combinationally to deq.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- io_enq_ready  out  1  queue can accept io_enq_bits this cycle.
- io_enq_valid  in  1  producer presents valid data.
- io_enq_bits  in  WIDTH  enqueue payload.
- io_deq_ready  in  1  consumer accepts head entry.
- io_deq_valid  out  1  head entry (or flow-through data) valid.
- io_deq_bits  out  WIDTH  head payload.
- io_count  out  $clog2(DEPTH+1)  current number of stored entries.

Behaviour:
- State:
  - enq_ptr, deq_ptr, each max($clog2(DEPTH),1) bits;
  - maybe_full flag;
  - storage mem[DEPTH][WIDTH], no reset on storage.
- Pointer increment: ptr+1, wrapping to 0 after DEPTH-1 (explicit compare, not a power-of-two overflow).
- Derived signals:
  - ptr_match = (enq_ptr == deq_ptr)
  - empty = ptr_match & ~maybe_full
  - full = ptr_match & maybe_full
- Handshake:
  - io_enq_ready = ~full, OR'd with io_deq_ready when PIPE=1.
  - io_deq_valid = ~empty, OR'd with io_enq_valid when FLOW=1.
  - io_deq_bits = mem[deq_ptr] combinationally; when FLOW=1 and empty, io_deq_bits = io_enq_bits.
- Firing:
  - do_enq = io_enq_valid & io_enq_ready
  - do_deq = io_deq_ready & io_deq_valid
  - FLOW=1 and empty: do_enq and do_deq are both internally suppressed when both sides fire. Data bypasses; pointers and storage are unchanged.
- Update, at the rising edge:
  - do_enq: mem[enq_ptr] <= io_enq_bits; enq_ptr advances.
  - do_deq: deq_ptr advances.
  - do_enq != do_deq: maybe_full <= do_enq.
- Latency:
  - Enqueue to io_deq_valid: 1 cycle (0 cycles with FLOW=1 and empty).
  - Throughput: 1 transfer/cycle; simultaneous enq+deq when neither empty nor full keeps the count unchanged.
- io_count:
  - full: DEPTH;
  - otherwise (enq_ptr - deq_ptr) mod DEPTH;
  - combinational from state, unaffected by flow-through.
- Reset: enq_ptr=0, deq_ptr=0, maybe_full=0.
  - Gives io_deq_valid=0 (FLOW=0), io_enq_ready=1, io_count=0 in the cycle after reset.
  - Reset mid-operation discards all contents; stale mem data is never visible because the queue is empty.
- Boundaries:
  - Enq while full (PIPE=0): ignored, ready low.
  - Deq while empty (FLOW=0): ignored.
  - Full with PIPE=1 and deq_ready=1: enq accepted, writes the slot being freed; count stays DEPTH.
  - DEPTH=1: the 1-bit pointers stay 0.
- io_deq_bits is undefined-but-stable when io_deq_valid=0; checkers must not compare it.

Optional Feature:
- Macro: TL_QUEUE_HIGH_WATER_EN.
- When defined:
  - adds output io_high_water, $clog2(DEPTH+1) bits;
  - holds the maximum io_count seen since reset;
  - reset value 0, updated one cycle after io_count changes;
  - saturates at DEPTH.
- When undefined: the port and register are absent; all other behaviour is identical.

Test Plan:
- DEPTH=2, WIDTH=2, PIPE=FLOW=0, deq_ready=0:
  - enq 2'b01 then 2'b10 -> io_count 1 then 2, io_enq_ready=0 after the second enq;
  - third enq is dropped;
  - after raising deq_ready, dequeues 2'b01 then 2'b10, then io_deq_valid=0.
- DEPTH=3, streaming: enq and deq every cycle for 10 values 0..9 (WIDTH=4) -> output order 0..9 through pointer wrap; io_count stays 1 after the first cycle.
- PIPE=1, DEPTH=2, full with deq_ready=1 and enq_valid=1 value 3 -> io_enq_ready=1, count stays 2, 3 emerges after the existing two entries.
- FLOW=1, empty queue, enq 2'b11 with deq_ready=1 -> same-cycle io_deq_valid=1, io_deq_bits=2'b11, io_count remains 0.
- Reset asserted for 1 cycle while holding 2 entries -> next cycle io_count=0, io_deq_valid=0, io_enq_ready=1; io_high_water=0 with TL_QUEUE_HIGH_WATER_EN.
- With TL_QUEUE_HIGH_WATER_EN, DEPTH=4: fill to 3, drain to 0 -> io_high_water=3 and stays 3.
